// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into 32-bit words
// and streams them out with auto-incrementing byte addresses.
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Count,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        Fmt,
    input  logic [6:0]        OpCode,
    input  logic [2:0]        F3,
    input  logic [6:0]        F7,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    input  logic [31:0]       Imm,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [31:0]       OutInstr,
    output logic [ADDR_W-1:0] OutAddr,
    output logic              Busy,
    output logic              Done,
    output logic              ErrIllegal
);

    localparam logic [2:0]  FMT_I = 3'b000;
    localparam logic [2:0]  FMT_S = 3'b001;
    localparam logic [2:0]  FMT_U = 3'b010;
    localparam logic [2:0]  FMT_J = 3'b011;
    localparam logic [2:0]  FMT_R = 3'b100;
    localparam logic [2:0]  FMT_B = 3'b101;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              done_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  rem;
    logic              accept;
    logic              out_hs;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              is_shift;
    logic              imm12_ok, imm13_ok, imm21_ok;

    // Range checks: the bits above the field's sign bit must all equal it.
    assign imm12_ok = (&Imm[31:11]) | ~(|Imm[31:11]);
    assign imm13_ok = (&Imm[31:12]) | ~(|Imm[31:12]);
    assign imm21_ok = (&Imm[31:20]) | ~(|Imm[31:20]);
    assign is_shift = (OpCode == 7'b0010011) && (F3 == 3'b001 || F3 == 3'b101);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        enc_word    = NOP;
        enc_illegal = 1'b0;
        case (Fmt)
            FMT_R: enc_word = {F7, Rs2, Rs1, F3, Rd, OpCode};
            FMT_I: begin
                if (is_shift) begin
                    enc_illegal = |Imm[31:5];
                    enc_word    = {F7, Imm[4:0], Rs1, F3, Rd, OpCode};
                end else begin
                    enc_illegal = !imm12_ok;
                    enc_word    = {Imm[11:0], Rs1, F3, Rd, OpCode};
                end
            end
            FMT_S: begin
                enc_illegal = !imm12_ok;
                enc_word    = {Imm[11:5], Rs2, Rs1, F3, Imm[4:0], OpCode};
            end
            FMT_B: begin
                enc_illegal = !imm13_ok || Imm[0];
                enc_word    = {Imm[12], Imm[10:5], Rs2, Rs1, F3, Imm[4:1], Imm[11], OpCode};
            end
            FMT_U: enc_word = {Imm[31:12], Rd, OpCode};
            FMT_J: begin
                enc_illegal = !imm21_ok || Imm[0];
                enc_word    = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, OpCode};
            end
            default: enc_illegal = 1'b1;
        endcase
        if (enc_illegal)
            enc_word = NOP;
    end

    assign InReady = (state == RUN) && (!OutValid || OutReady);
    assign accept  = InValid && InReady;
    assign out_hs  = OutValid && OutReady;
    assign Busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Count == '0) done_nxt  = 1'b1;
                    else             state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && rem == CNT_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!OutValid || OutReady) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            OutValid   <= 1'b0;
            OutInstr   <= '0;
            OutAddr    <= '0;
            Done       <= 1'b0;
            ErrIllegal <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= done_nxt;
            if (state == IDLE && Start) begin
                addr       <= BASE_ADDR;
                rem        <= Count;
                ErrIllegal <= 1'b0;
            end
            if (accept) begin
                OutInstr <= enc_word;
                OutAddr  <= addr;
                addr     <= addr + ADDR_W'(4);
                rem      <= rem - CNT_W'(1);
                if (enc_illegal)
                    ErrIllegal <= 1'b1;
            end
            // A new word takes priority over clearing on a same-cycle output handshake.
            if (accept)      OutValid <= 1'b1;
            else if (out_hs) OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed encodings, stalls,
// illegal bundles, mid-burst reset and randomized bursts against a field-level model.
module tb_rv32i_instr_encoder;

    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Count = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  Fmt = '0;
    logic [6:0]  OpCode = '0;
    logic [2:0]  F3 = '0;
    logic [6:0]  F7 = '0;
    logic [4:0]  Rd = '0, Rs1 = '0, Rs2 = '0;
    logic [31:0] Imm = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutInstr;
    logic [31:0] OutAddr;
    logic        Busy, Done, ErrIllegal;

    bundle_t     bq[$];
    logic [31:0] exp_i[$], exp_a[$], got_i[$], got_a[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Count(Count),
        .InValid(InValid), .InReady(InReady), .Fmt(Fmt), .OpCode(OpCode),
        .F3(F3), .F7(F7), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Imm(Imm),
        .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr),
        .OutAddr(OutAddr), .Busy(Busy), .Done(Done), .ErrIllegal(ErrIllegal)
    );

    function automatic bundle_t mk(logic [2:0] fmt, logic [6:0] op, logic [2:0] f3,
                                   logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1,
                                   logic [4:0] rs2, logic [31:0] imm);
        bundle_t b;
        b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    // Reference encoder: plain shifts/masks and signed range tests on the immediate.
    function automatic void ref_encode(input bundle_t b, output logic [31:0] word, output logic ill);
        longint      si;
        logic [31:0] op, f3, f7, rd, rs1, rs2, im;
        si  = longint'($signed(b.imm));
        im  = b.imm;
        op  = 32'(b.op);  f3  = 32'(b.f3);  f7  = 32'(b.f7);
        rd  = 32'(b.rd);  rs1 = 32'(b.rs1); rs2 = 32'(b.rs2);
        ill  = 1'b0;
        word = 32'h0;
        case (b.fmt)
            3'd4: word = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd0: begin
                if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
                    ill  = (im > 32'd31);
                    word = (f7 << 25) | ((im & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                end else begin
                    ill  = (si < -2048) || (si > 2047);
                    word = ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                end
            end
            3'd1: begin
                ill  = (si < -2048) || (si > 2047);
                word = (((im >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | ((im & 32'h1F) << 7) | op;
            end
            3'd5: begin
                ill  = (si < -4096) || (si > 4095) || (im % 2 == 1);
                word = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (rs2 << 20)
                     | (rs1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                     | (((im >> 11) & 1) << 7) | op;
            end
            3'd2: word = (im & 32'hFFFF_F000) | (rd << 7) | op;
            3'd3: begin
                ill  = (si < -(64'sd1 << 20)) || (si > (64'sd1 << 20) - 1) || (im % 2 == 1);
                word = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                     | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            end
            default: ill = 1'b1;
        endcase
        if (ill) word = NOP;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [11:0] s12;
        logic [12:0] s13;
        logic [20:0] s21;
        b.fmt = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        case ($urandom_range(0, 3))
            0:       b.op = 7'h13;
            1:       b.op = 7'h33;
            2:       b.op = 7'h63;
            default: b.op = 7'($urandom);
        endcase
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        s12 = 12'($urandom); s13 = 13'($urandom); s21 = 21'($urandom);
        case ($urandom_range(0, 6))
            0: b.imm = $urandom;
            1: b.imm = 32'($urandom_range(0, 40));
            2: case ($urandom_range(0, 9))
                   0: b.imm = 32'd2047;      1: b.imm = -32'sd2048;
                   2: b.imm = 32'd2048;      3: b.imm = -32'sd2049;
                   4: b.imm = 32'd4094;      5: b.imm = 32'd4096;
                   6: b.imm = -32'sd4096;    7: b.imm = 32'd1048574;
                   8: b.imm = -32'sd1048576; default: b.imm = 32'd1048576;
               endcase
            3: b.imm = {{20{s12[11]}}, s12};
            4: b.imm = {{19{s13[12]}}, s13[12:1], 1'b0};
            5: b.imm = {{11{s21[20]}}, s21[20:1], 1'b0};
            default: b.imm = $urandom & 32'hFFFF_F000;
        endcase
        return b;
    endfunction

    task automatic put_fields(input bundle_t b);
        Fmt = b.fmt; OpCode = b.op; F3 = b.f3; F7 = b.f7;
        Rd = b.rd; Rs1 = b.rs1; Rs2 = b.rs2; Imm = b.imm;
    endtask

    // Runs one burst of n bundles from bq. ready_mode: 0 random, 1 always ready,
    // 2 hold OutReady low for the first three cycles the first word is valid.
    task automatic do_burst(input int n, input int ready_mode, input int valid_pct, input bit rand_start);
        int          sent, last_ev, stall_left;
        bit          done_seen;
        logic        err_m, ill, pv, pr;
        logic [31:0] addr_m, w, pi, pa;
        exp_i.delete(); exp_a.delete(); got_i.delete(); got_a.delete();
        @(negedge clk);
        Start = 1'b1; Count = 16'(n); InValid = 1'b0; OutReady = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        addr_m = BASE; err_m = 1'b0; sent = 0; last_ev = -1; stall_left = 3;
        done_seen = 1'b0; pv = 1'b0; pr = 1'b1; pi = '0; pa = '0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            n_checks++;
            if (ErrIllegal !== err_m) begin
                n_fail++; $display("FAIL err_illegal: got %b expected %b (cycle %0d)", ErrIllegal, err_m, cyc);
            end
            n_checks++;
            if (Busy !== !Done) begin
                n_fail++; $display("FAIL busy: got %b with Done=%b (cycle %0d)", Busy, Done, cyc);
            end
            if (pv && !pr) begin
                n_checks++;
                if (OutValid !== 1'b1 || OutInstr !== pi || OutAddr !== pa) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b %h@%h expected v=1 %h@%h", OutValid, OutInstr, OutAddr, pi, pa);
                end
            end
            if (Done === 1'b1) begin
                done_seen = 1'b1;
                n_checks++;
                if (cyc != last_ev + 1 || sent != n || exp_i.size() != 0) begin
                    n_fail++;
                    $display("FAIL done_timing: done at cycle %0d sent %0d pending %0d, expected cycle %0d sent %0d pending 0",
                             cyc, sent, exp_i.size(), last_ev + 1, n);
                end
            end else begin
                Start = rand_start ? ($urandom_range(0, 3) == 0) : 1'b0;
                Count = 16'($urandom);
                InValid = (sent < n) && ($urandom_range(1, 100) <= valid_pct);
                if (sent < n) put_fields(bq[0]);
                else          put_fields(rand_bundle());
                case (ready_mode)
                    0: OutReady = ($urandom_range(0, 2) != 0);
                    1: OutReady = 1'b1;
                    default: begin
                        if (OutValid && stall_left > 0) begin
                            OutReady = 1'b0; stall_left--;
                        end else OutReady = 1'b1;
                    end
                endcase
                #1;
                n_checks++;
                if (InReady !== ((sent < n) && (!OutValid || OutReady))) begin
                    n_fail++;
                    $display("FAIL in_ready: got %b expected %b (cycle %0d)", InReady, (sent < n) && (!OutValid || OutReady), cyc);
                end
                if (OutValid && OutReady) begin
                    got_i.push_back(OutInstr); got_a.push_back(OutAddr);
                    n_checks++;
                    if (exp_i.size() == 0) begin
                        n_fail++; $display("FAIL out_word: got %h@%h expected no output", OutInstr, OutAddr);
                    end else begin
                        if (OutInstr !== exp_i[0] || OutAddr !== exp_a[0]) begin
                            n_fail++;
                            $display("FAIL out_word: got %h@%h expected %h@%h", OutInstr, OutAddr, exp_i[0], exp_a[0]);
                        end
                        void'(exp_i.pop_front()); void'(exp_a.pop_front());
                    end
                    last_ev = cyc;
                end
                if (InValid && InReady) begin
                    ref_encode(bq.pop_front(), w, ill);
                    exp_i.push_back(w); exp_a.push_back(addr_m);
                    addr_m = addr_m + 32'd4;
                    if (ill) err_m = 1'b1;
                    sent++;
                end
                pv = OutValid; pr = OutReady; pi = OutInstr; pa = OutAddr;
                @(negedge clk);
            end
        end
        Start = 1'b0; InValid = 1'b0;
        n_checks++;
        if (!done_seen) begin
            n_fail++; $display("FAIL burst_timeout: got no Done expected Done within budget");
        end
        @(negedge clk);
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL done_single: got Done=%b Busy=%b expected 0 0", Done, Busy);
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({OutValid, InReady, Busy, Done, ErrIllegal} !== 5'b0 || OutInstr !== 32'h0 || OutAddr !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: got v=%b r=%b b=%b d=%b e=%b %h@%h expected all 0",
                               OutValid, InReady, Busy, Done, ErrIllegal, OutInstr, OutAddr);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({OutValid, InReady, Busy, Done, ErrIllegal} !== 5'b0) begin
            n_fail++; $display("FAIL reset_idle: got v=%b r=%b b=%b d=%b e=%b expected all 0",
                               OutValid, InReady, Busy, Done, ErrIllegal);
        end
    endtask

    task automatic test_single(input string name, input bundle_t b, input logic [31:0] want, input logic want_err);
        bq.delete(); bq.push_back(b);
        do_burst(1, 1, 100, 1'b0);
        n_checks++;
        if (got_i.size() != 1 || got_i[0] !== want || got_a[0] !== BASE || ErrIllegal !== want_err) begin
            n_fail++;
            $display("FAIL %s: got %0d words first %h@%h err %b expected %h@%h err %b", name, got_i.size(),
                     (got_i.size() > 0) ? got_i[0] : 32'hx, (got_a.size() > 0) ? got_a[0] : 32'hx,
                     ErrIllegal, want, BASE, want_err);
        end
    endtask

    task automatic test_stall;
        bq.delete();
        for (int i = 0; i < 3; i++) bq.push_back(mk(3'd4, 7'h33, 3'd0, 7'h00, 5'(i + 1), 5'd1, 5'd2, 32'h0));
        do_burst(3, 2, 100, 1'b0);
        n_checks++;
        if (got_a.size() != 3 || got_a[0] !== 32'h0 || got_a[1] !== 32'h4 || got_a[2] !== 32'h8) begin
            n_fail++; $display("FAIL stall_addrs: got %0d words expected addresses 0,4,8", got_a.size());
        end
    endtask

    task automatic test_count_zero;
        do_burst(0, 1, 100, 1'b0);
        n_checks++;
        if (ErrIllegal !== 1'b0 || got_i.size() != 0) begin
            n_fail++; $display("FAIL count_zero: got err %b words %0d expected err 0 words 0", ErrIllegal, got_i.size());
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        Start = 1'b1; Count = 16'd4;
        @(negedge clk);
        Start = 1'b0; put_fields(mk(3'd4, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0));
        InValid = 1'b1; OutReady = 1'b0;
        @(negedge clk);
        InValid = 1'b0;
        n_checks++;
        if (OutValid !== 1'b1 || Busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_precond: got v=%b busy=%b expected 1 1", OutValid, Busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (OutValid !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got v=%b busy=%b expected 0 0", OutValid, Busy);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_no_done: got Done=%b Busy=%b expected 0 0", Done, Busy);
            end
        end
        bq.delete(); bq.push_back(mk(3'd2, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
        do_burst(1, 1, 100, 1'b0);
        n_checks++;
        if (got_a.size() != 1 || got_a[0] !== BASE || got_i[0] !== 32'h1234_52B7) begin
            n_fail++; $display("FAIL mid_restart: got %0d words expected lui 123452b7 at base", got_a.size());
        end
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 8);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(rand_bundle());
            do_burst(n, 0, 70, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single("r_add",    mk(3'd4, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0),         32'h0020_81B3, 1'b0);
        test_single("i_addi",   mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b0);
        test_single("b_beq",    mk(3'd5, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8),         32'h0020_8463, 1'b0);
        test_stall();
        test_single("b_odd",    mk(3'd5, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7),         NOP,           1'b1);
        test_count_zero();
        test_single("fmt_bad",  mk(3'd6, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0),         NOP,           1'b1);
        test_single("slli_bad", mk(3'd0, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32),        NOP,           1'b1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
